// File: rtl/trng_reader.sv
// trng_reader: captures completed TRNG keys into a FIFO, restarts the TRNG, and exposes DATA/STATUS/CTRL registers.
module trng_reader #(
  parameter int DEPTH      = 4,
  parameter int KEY_W      = 10,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_ready_in,
  output logic             trng_rst,
  input  logic [1:0]       addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             rd_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_KEY = 2'd1, RESTART = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             en_q, en_d, uf_q, uf_d, rd_valid_q, rd_valid_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [31:0]      rdata_q, rdata_d, status;
  logic             push, pop, flush, empty, full, rd_data;
  logic             unused;

  assign unused = ^{wdata[31:17], wdata[15:2]};

  always_comb begin
    empty      = count_q == '0;
    full       = count_q == CW'(DEPTH);
    rd_data    = rd_en && addr == 2'd0;
    flush      = wr_en && addr == 2'd2 && wdata[1];
    en_d       = (wr_en && addr == 2'd2) ? wdata[0] : en_q;
    pop        = rd_data && !empty;
    // capture looks at the pre-pop count, so a freed slot is used on the following cycle
    push       = state_q == WAIT_KEY && en_q && key_ready_in && !full;
    status     = {6'b0, state_q, 6'b0, key_ready_in & full, uf_q, 6'b0, full, empty, 3'b0, 5'(count_q)};
    state_d    = !en_q ? IDLE :
                 state_q == IDLE ? WAIT_KEY :
                 state_q == WAIT_KEY ? (push ? RESTART : WAIT_KEY) :
                 rcnt_q == RW'(1) ? WAIT_KEY : RESTART;
    rcnt_d     = push ? RW'(RST_CYCLES) : state_q == RESTART ? rcnt_q - RW'(1) : rcnt_q;
    count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
    wptr_d     = flush ? '0 : wptr_q + PW'(push);
    rptr_d     = flush ? '0 : rptr_q + PW'(pop);
    uf_d       = (rd_data && empty) ? 1'b1 : (wr_en && addr == 2'd1 && wdata[16]) ? 1'b0 : uf_q;
    rdata_d    = !rd_en ? rdata_q :
                 addr == 2'd0 ? (empty ? 32'd0 : 32'(mem_q[rptr_q])) :
                 addr == 2'd1 ? status :
                 addr == 2'd2 ? {31'd0, en_q} : 32'd0;
    rd_valid_d = rd_en;
    trng_rst   = state_q != WAIT_KEY;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      uf_q       <= 1'b0;
      rcnt_q     <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      uf_q       <= uf_d;
      rcnt_q     <= rcnt_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= key_in;
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
endmodule
